// File: rtl/accel_pkg.sv
// Shared accelerator definitions: weight-fetch FSM encoding, default bus widths
// shared with the weight BRAM instances, and a small modular-increment helper.
package accel_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // (v + 1) mod n without relying on n being a power of two
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select: one-hot grant searched upward from the pointer,
// pointer moves to the slot after the winner when the grant is taken.
module rr_arbiter
    import accel_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int unsigned cand;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!any && req[IDX_W'(cand)]) begin
                any                   = 1'b1;
                grant[IDX_W'(cand)]   = 1'b1;
                grant_idx             = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take && any) begin
            ptr <= IDX_W'(wrap_inc(32'(grant_idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/weight_fetch_arbiter.sv
// Shares one single-port weight BRAM between NUM_REQ engines: round-robin burst
// grants, one read per cycle, words returned tagged one-hot to the burst owner.
module weight_fetch_arbiter
    import accel_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic                          bram_rd_en,
    input  logic [DATA_WIDTH-1:0]         bram_dout,
    input  logic                          bram_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_last,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    fetch_state_t           state, state_next;
    logic [IDX_W-1:0]       owner, owner_next;
    logic [LEN_WIDTH-1:0]   len_q, len_next;
    logic [LEN_WIDTH-1:0]   issue_cnt, issue_next;
    logic [LEN_WIDTH-1:0]   rx_cnt, rx_next;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic                   rd_en_next;
    logic [DATA_WIDTH-1:0]  data_next;
    logic [NUM_REQ-1:0]     rsp_valid_next;
    logic                   last_next;
    logic [NUM_REQ-1:0]     done_next;
    logic                   take;

    logic [NUM_REQ-1:0]     sel_oh;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_any;
    logic [ADDR_WIDTH-1:0]  sel_base;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic [NUM_REQ-1:0]     owner_oh;
    logic                   idle;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .take      (take),
        .grant     (sel_oh),
        .grant_idx (sel_idx),
        .any       (sel_any)
    );

    assign idle      = (state == IDLE);
    assign sel_base  = req_base[32'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len   = req_len[32'(sel_idx) * LEN_WIDTH +: LEN_WIDTH];
    assign owner_oh  = NUM_REQ'(1) << owner;
    // Grant is only offered while idle and out of reset
    assign req_ready = (idle && rst_n) ? sel_oh : '0;

    always_comb begin
        state_next     = state;
        owner_next     = owner;
        len_next       = len_q;
        issue_next     = issue_cnt;
        rx_next        = rx_cnt;
        addr_next      = bram_addr;
        rd_en_next     = 1'b0;
        data_next      = rsp_data;
        rsp_valid_next = '0;
        last_next      = 1'b0;
        done_next      = '0;
        take           = 1'b0;

        unique case (state)
            IDLE: begin
                if (sel_any) begin
                    take       = 1'b1;
                    owner_next = sel_idx;
                    len_next   = sel_len;
                    issue_next = '0;
                    rx_next    = '0;
                    if (sel_len != '0) begin
                        state_next = ISSUE;
                        rd_en_next = 1'b1;
                        addr_next  = sel_base;
                    end else begin
                        done_next = sel_oh;
                    end
                end
            end
            ISSUE: begin
                issue_next = issue_cnt + LEN_WIDTH'(1);
                if (issue_cnt == len_q - LEN_WIDTH'(1)) begin
                    state_next = DRAIN;
                end else begin
                    rd_en_next = 1'b1;
                    addr_next  = bram_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
            end
            default: state_next = IDLE;
        endcase

        // Read data is only accepted while a burst owns the BRAM
        if ((state == ISSUE || state == DRAIN) && bram_valid) begin
            data_next      = bram_dout;
            rsp_valid_next = owner_oh;
            rx_next        = rx_cnt + LEN_WIDTH'(1);
            if (rx_cnt == len_q - LEN_WIDTH'(1)) begin
                last_next = 1'b1;
                done_next = owner_oh;
                if (state == DRAIN) begin
                    state_next = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            rx_cnt     <= '0;
            bram_addr  <= '0;
            bram_rd_en <= 1'b0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
            rsp_last   <= 1'b0;
            done       <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            len_q      <= len_next;
            issue_cnt  <= issue_next;
            rx_cnt     <= rx_next;
            bram_addr  <= addr_next;
            bram_rd_en <= rd_en_next;
            rsp_data   <= data_next;
            rsp_valid  <= rsp_valid_next;
            rsp_last   <= last_next;
            done       <= done_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Self-checking bench for weight_fetch_arbiter: directed burst table, round-robin
// and reset/stray corner sequences, then random traffic against a timing model.
module tb_weight_fetch_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_base;
    logic [NR*LW-1:0] req_len;
    logic [AW-1:0]   bram_addr;
    logic            bram_rd_en;
    logic [DW-1:0]   bram_dout;
    logic            bram_valid;
    logic [DW-1:0]   rsp_data;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_last;
    logic [NR-1:0]   done;
    logic            busy;

    weight_fetch_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_base   (req_base),
        .req_len    (req_len),
        .bram_addr  (bram_addr),
        .bram_rd_en (bram_rd_en),
        .bram_dout  (bram_dout),
        .bram_valid (bram_valid),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_last   (rsp_last),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Weight BRAM: one-cycle registered read, plus an injectable stray valid
    logic [DW-1:0] mem [4096];
    logic          bv_q = 1'b0;
    logic [DW-1:0] bd_q = '0;
    logic          stray = 1'b0;
    always @(posedge clk) begin
        bv_q <= bram_rd_en;
        bd_q <= mem[bram_addr];
    end
    assign bram_valid = bv_q | stray;
    assign bram_dout  = bd_q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] b, input logic [LW-1:0] l);
        req_base[i*AW +: AW] = b;
        req_len[i*LW +: LW]  = l;
    endtask

    // Transaction-level model: one burst record; all timing derived from the grant cycle
    bit          chk_en = 1'b0;
    bit          m_act = 1'b0;
    int          m_g = 0;
    int          m_len = 0;
    int          m_own = 0;
    int          m_ptr = 0;
    logic [AW-1:0] m_base = '0;
    int          m_zd_c = -10;
    int          m_zd_own = 0;
    logic [NR-1:0] hs_last = '0;

    function automatic bit model_busy(input int c);
        return m_act && (c >= m_g + 1) && (c <= m_g + m_len + 1);
    endfunction

    always @(negedge clk) begin
        int c, pick;
        bit e_rd, e_rsp, free;
        logic [NR-1:0] e_ready, e_rv, e_done;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        c = cyc;
        hs_last = req_valid & req_ready;
        if (!rst_n) begin
            m_act   = 1'b0;
            m_ptr   = 0;
            m_zd_c  = -10;
            hs_last = '0;
        end else if (chk_en) begin
            e_rd  = m_act && (c >= m_g + 1) && (c <= m_g + m_len);
            e_rsp = m_act && (c >= m_g + 3) && (c <= m_g + m_len + 2);
            free  = !m_act || (c >= m_g + m_len + 2);
            e_addr = AW'(int'(m_base) + c - m_g - 1);
            e_data = mem[AW'(int'(m_base) + c - m_g - 3)];
            e_rv   = e_rsp ? NR'(1 << m_own) : '0;
            e_done = (e_rsp && c == m_g + m_len + 2) ? NR'(1 << m_own) : '0;
            if (m_zd_c == c) e_done = e_done | NR'(1 << m_zd_own);
            e_ready = '0;
            pick = -1;
            if (free) begin
                for (int k = 0; k < NR; k++) begin
                    if (pick < 0 && req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
                end
                if (pick >= 0) e_ready[pick] = 1'b1;
            end
            chk("req_ready", req_ready, e_ready);
            chk("bram_rd_en", bram_rd_en, e_rd);
            if (e_rd) chk("bram_addr", bram_addr, e_addr);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rsp) chk("rsp_data", rsp_data, e_data);
            chk("rsp_last", rsp_last, e_rsp && (c == m_g + m_len + 2));
            chk("done", done, e_done);
            chk("busy", busy, model_busy(c));
            if (pick >= 0) begin
                m_ptr = (pick + 1) % NR;
                if (req_len[pick*LW +: LW] == '0) begin
                    m_zd_c   = c + 1;
                    m_zd_own = pick;
                end else begin
                    m_act  = 1'b1;
                    m_g    = c;
                    m_own  = pick;
                    m_len  = int'(req_len[pick*LW +: LW]);
                    m_base = req_base[pick*AW +: AW];
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_burst(input int idx, input logic [AW-1:0] b, input logic [LW-1:0] l,
                             output int rd_n, output logic [AW-1:0] a_first,
                             output logic [AW-1:0] a_last, output int lat, output int rsp_n);
        int gc;
        bit got;
        rd_n = 0; rsp_n = 0; lat = -1; a_first = '0; a_last = '0; got = 1'b0;
        set_req(idx, b, l);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1'b1;
        end
        gc = cyc;
        chk("grant_seen", got, 1);
        tick();
        req_valid = '0;
        set_req(idx, ~b, ~l);
        for (int w = 0; w < int'(l) + 10; w++) begin
            @(negedge clk);
            if (bram_rd_en) begin
                if (rd_n == 0) a_first = bram_addr;
                a_last = bram_addr;
                rd_n++;
            end
            if (rsp_valid[idx]) rsp_n++;
            if (done[idx]) begin
                lat = cyc - gc;
                break;
            end
        end
        tick();
    endtask

    typedef struct {
        int            idx;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            exp_rd;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        int            exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int rd_n, lat, rsp_n, ng, last_done, gown, gc;
        int dcount [NR];
        logic [AW-1:0] a_first, a_last;

        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
        rst_n = 1'b0; req_valid = '0; req_base = '0; req_len = '0; stray = 1'b0;

        vecs[0] = '{0, 12'h010, 8'd4,   4,   12'h010, 12'h013, 6};
        vecs[1] = '{1, 12'hFFE, 8'd4,   4,   12'hFFE, 12'h001, 6};
        vecs[2] = '{2, 12'h100, 8'd0,   0,   12'h000, 12'h000, 1};
        vecs[3] = '{3, 12'h7FF, 8'd1,   1,   12'h7FF, 12'h7FF, 3};
        vecs[4] = '{0, 12'h020, 8'd255, 255, 12'h020, 12'h11E, 257};
        vecs[5] = '{1, 12'hFF0, 8'd32,  32,  12'hFF0, 12'h00F, 34};

        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", bram_rd_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 0);
        chk_en = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].idx, vecs[v].base, vecs[v].len, rd_n, a_first, a_last, lat, rsp_n);
            chk("tbl_rd_cnt", rd_n, vecs[v].exp_rd);
            chk("tbl_first_addr", a_first, vecs[v].exp_first);
            chk("tbl_last_addr", a_last, vecs[v].exp_last);
            chk("tbl_done_lat", lat, vecs[v].exp_lat);
            chk("tbl_rsp_cnt", rsp_n, int'(vecs[v].len));
        end

        // All four held with len=2: grants 0,1,2,3,0, each regrant on the rsp_last cycle
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_req(i, AW'(i * 64), 8'd2);
            dcount[i] = 0;
        end
        req_valid = '1;
        ng = 0; last_done = -1;
        for (int w = 0; w < 80 && ng < 5; w++) begin
            @(negedge clk);
            if (done != '0) begin
                last_done = cyc;
                for (int k = 0; k < NR; k++) if (done[k]) dcount[k]++;
            end
            if (req_ready != '0) begin
                gown = -1;
                for (int k = 0; k < NR; k++) if (req_ready[k]) gown = k;
                chk("rr_owner", gown, ng % NR);
                if (ng > 0) chk("rr_regrant_cycle", cyc, last_done);
                ng++;
            end
        end
        tick();
        req_valid = '0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) if (done[k]) dcount[k]++;
        end
        tick();
        chk("rr_grants", ng, 5);
        chk("rr_done0", dcount[0], 2);
        chk("rr_done1", dcount[1], 1);
        chk("rr_done2", dcount[2], 1);
        chk("rr_done3", dcount[3], 1);

        // Reset on the second ISSUE cycle of a len=8 burst
        set_req(3, 12'h200, 8'd8);
        req_valid = 4'b1000;
        gc = -1;
        for (int w = 0; w < 20 && gc < 0; w++) begin
            @(negedge clk);
            if (req_ready[3]) gc = cyc;
        end
        chk("mid_grant", gc >= 0, 1);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_issuing", bram_rd_en, 1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_rd_en", bram_rd_en, 0);
        chk("mid_addr", bram_addr, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_last", rsp_last, 0);
        chk("mid_done", done, 0);
        tick();
        @(negedge clk);
        chk("mid_late_rsp", rsp_valid, 0);
        chk("mid_late_done", done, 0);
        tick();

        // Stray BRAM valid while idle
        for (int k = 0; k < 3; k++) begin
            stray = 1'b1;
            tick();
            stray = 1'b0;
            @(negedge clk);
            chk("stray_rsp", rsp_valid, 0);
            chk("stray_done", done, 0);
            chk("stray_busy", busy, 0);
            tick();
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (hs_last[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) == 0);
                    set_req(i, AW'($urandom),
                            ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 40))
                                                        : LW'($urandom_range(0, 6)));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_req(i, AW'($urandom),
                                ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 40))
                                                            : LW'($urandom_range(0, 6)));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            stray = !model_busy(cyc) && ($urandom_range(0, 7) == 0);
        end
        tick();
        req_valid = '0;
        stray = 1'b0;
        rst_n = 1'b1;
        for (int w = 0; w < 60; w++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
